c2_line_arbiter: RTL and testbench

- Sequencer and arbiter for the level-2 memory bus (C2/A2/D2) in front of the memory controller.
- Accepts whole-line read/write requests from two requesters (e.g. two L1 caches, or cache plus write-back buffer) and grants the bus round-robin.
- Drives the C2 command, A2 line address and D2 write beats, then collects the memory RESPONSE and read beats.
- All bus outputs come as value/output-enable pairs; the tristate drivers live at top level.

---
 rtl/c2_bus_pkg.sv | 31 +++
 rtl/c2_line_arbiter_if.sv | 40 ++++
 rtl/c2_line_arbiter_rr_arb2.sv | 33 +++
 rtl/c2_line_arbiter.sv | 177 +++++++++++++++++
 tb/tb_c2_line_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/c2_bus_pkg.sv
// Shared definitions for the level-2 memory bus (C2 command, A2 address, D2 data).
// Command codes, sequencer states and default bus geometry.
package c2_bus_pkg;

    localparam int ADDR_W_DEF  = 15;
    localparam int DATA_W_DEF  = 16;
    localparam int BEATS_DEF   = 8;
    localparam int TIMEOUT_DEF = 512;

    typedef logic [1:0] c2_cmd_t;

    localparam c2_cmd_t CMD_NOP        = 2'd0;
    localparam c2_cmd_t CMD_RESPONSE   = 2'd1;
    localparam c2_cmd_t CMD_READ_LINE  = 2'd2;
    localparam c2_cmd_t CMD_WRITE_LINE = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CMD       = 3'd1,
        ST_WR_BEATS  = 3'd2,
        ST_TURN      = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_RD_BEATS  = 3'd5,
        ST_DONE      = 3'd6
    } state_e;

    function automatic c2_cmd_t line_cmd(input logic is_write);
        return is_write ? CMD_WRITE_LINE : CMD_READ_LINE;
    endfunction

endpackage

// File: rtl/c2_line_arbiter_if.sv
// Requester-side handshake plus C2/A2/D2 bus pins of the line arbiter.
// master = the arbiter, slave = requesters and memory-side bus model.
interface c2_line_arbiter_if
    import c2_bus_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic [1:0]             req_valid;
    logic [1:0]             req_write;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][DATA_W-1:0] req_wdata;
    logic [1:0]             req_ack;
    logic [2:0]             wbeat_idx;
    logic [DATA_W-1:0]      rd_data;
    logic                   rd_valid;
    logic                   rsp_id;
    logic [1:0]             done;
    logic                   err;
    logic [1:0]             c2_o;
    logic                   c2_oe;
    logic [ADDR_W-1:0]      a2_o;
    logic [DATA_W-1:0]      d2_o;
    logic                   d2_oe;
    logic [1:0]             c2_i;
    logic [DATA_W-1:0]      d2_i;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, c2_i, d2_i,
        output req_ack, wbeat_idx, rd_data, rd_valid, rsp_id, done, err,
               c2_o, c2_oe, a2_o, d2_o, d2_oe
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, c2_i, d2_i,
        input  req_ack, wbeat_idx, rd_data, rd_valid, rsp_id, done, err,
               c2_o, c2_oe, a2_o, d2_o, d2_oe
    );

endinterface

// File: rtl/c2_line_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the preferred requester and
// moves to the loser only when the caller actually takes the grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);
    logic rr_q, rr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (req_i[rr_q])
            gnt_o[rr_q] = 1'b1;
        else if (req_i[~rr_q])
            gnt_o[~rr_q] = 1'b1;
    end

    always_comb begin
        rr_d = rr_q;
        if (advance_i && (|gnt_o))
            rr_d = ~gnt_o[1];
    end

    always_ff @(posedge clk) begin
        if (rst_i)
            rr_q <= 1'b0;
        else
            rr_q <= rr_d;
    end

endmodule

// File: rtl/c2_line_arbiter.sv
// Line-transfer sequencer for the C2/A2/D2 bus: grants one of two requesters,
// issues the command and write beats, then waits for RESPONSE and read beats.
module c2_line_arbiter
    import c2_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int BEATS   = BEATS_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic               clk,
    input logic               RESET,
    c2_line_arbiter_if.master bus
);
    localparam int           TO_W    = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [2:0]   BEAT_LAST = 3'(BEATS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              rsp_id_q, rsp_id_d;
    logic [2:0]        beat_q, beat_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic [1:0] gnt;
    logic       grant_vld;
    logic       g;
    logic       resp_seen;

    // Grants only come out of IDLE; a held reset must not look like an ack.
    assign grant_vld = (state_q == ST_IDLE) && (|bus.req_valid) && !RESET;
    assign g         = gnt[1];
    assign resp_seen = (bus.c2_i == CMD_RESPONSE);

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_i     (RESET),
        .req_i     (bus.req_valid),
        .advance_i (grant_vld),
        .gnt_o     (gnt)
    );

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            rsp_id_q   <= 1'b0;
            beat_q     <= '0;
            to_q       <= '0;
            err_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            rsp_id_q   <= rsp_id_d;
            beat_q     <= beat_d;
            to_q       <= to_d;
            err_q      <= err_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        rsp_id_d   = rsp_id_q;
        beat_d     = beat_q;
        to_d       = to_q;
        err_d      = err_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_vld) begin
                    addr_d   = bus.req_addr[g];
                    wr_d     = bus.req_write[g];
                    rsp_id_d = g;
                    err_d    = 1'b0;
                    beat_d   = '0;
                    state_d  = ST_CMD;
                end
            end
            ST_CMD: begin
                if (wr_q) begin
                    beat_d  = 3'd1;
                    state_d = ST_WR_BEATS;
                end else begin
                    state_d = ST_TURN;
                end
            end
            ST_WR_BEATS: begin
                if (beat_q == BEAT_LAST) begin
                    beat_d  = '0;
                    state_d = ST_TURN;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            ST_TURN: begin
                to_d    = '0;
                state_d = ST_WAIT_RESP;
            end
            ST_WAIT_RESP: begin
                if (to_q != TO_LAST)
                    to_d = to_q + 1'b1;
                // RESPONSE wins even on the final timeout cycle.
                if (resp_seen) begin
                    if (wr_q) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = bus.d2_i;
                        beat_d     = 3'd1;
                        state_d    = ST_RD_BEATS;
                    end
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_RD_BEATS: begin
                rd_valid_d = 1'b1;
                rd_data_d  = bus.d2_i;
                if (beat_q == BEAT_LAST) begin
                    beat_d  = '0;
                    state_d = ST_DONE;
                end else begin
                    beat_d = beat_q + 3'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ack   = grant_vld ? gnt : 2'b00;
        bus.c2_oe     = 1'b0;
        bus.c2_o      = CMD_NOP;
        bus.a2_o      = '0;
        bus.d2_oe     = 1'b0;
        bus.d2_o      = '0;
        bus.wbeat_idx = '0;
        bus.done      = 2'b00;
        bus.err       = 1'b0;
        bus.rd_data   = rd_data_q;
        bus.rd_valid  = rd_valid_q;
        bus.rsp_id    = rsp_id_q;

        if (state_q == ST_CMD || state_q == ST_WR_BEATS) begin
            bus.c2_oe = 1'b1;
            bus.c2_o  = line_cmd(wr_q);
            bus.a2_o  = addr_q;
            if (wr_q) begin
                bus.d2_oe     = 1'b1;
                bus.wbeat_idx = beat_q;
                bus.d2_o      = bus.req_wdata[rsp_id_q];
            end
        end

        if (state_q == ST_DONE) begin
            bus.done[rsp_id_q] = 1'b1;
            bus.err            = err_q;
        end
    end

endmodule

// File: tb/tb_c2_line_arbiter.sv
// Bench for c2_line_arbiter: directed transaction table, reset corner case and
// random transactions, all checked cycle by cycle against a transaction schedule.
module tb_c2_line_arbiter;
    import c2_bus_pkg::*;

    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic RESET;
    always #5 clk = ~clk;

    c2_line_arbiter_if #(.ADDR_W(15), .DATA_W(16)) ifc ();

    c2_line_arbiter #(.ADDR_W(15), .DATA_W(16), .BEATS(8), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .RESET (RESET),
        .bus   (ifc.master)
    );

    // Requesters present their write beat as a function of wbeat_idx.
    logic [15:0] wline [2][8];
    always_comb begin
        for (int r = 0; r < 2; r++)
            ifc.req_wdata[r] = wline[r][ifc.wbeat_idx];
    end

    typedef struct packed {
        logic [1:0]  ack;
        logic        c2_oe;
        logic [1:0]  c2;
        logic [14:0] a2;
        logic        d2_oe;
        logic [15:0] d2;
        logic [2:0]  wb;
        logic        rdv;
        logic [15:0] rdd;
        logic [1:0]  done;
        logic        err;
        logic        rid;
    } obs_t;

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  write;
        logic [14:0] a0;
        logic [14:0] a1;
        int          delay;
        bit          pat;
        bit          noise;
        logic [1:0]  exp_ack;
        logic        exp_err;
    } vec_t;

    int          n_chk, n_fail;
    int          m_rr;
    logic        m_rid;
    logic [15:0] m_rd;
    int          txn_id;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.ack   = ifc.req_ack;
        o.c2_oe = ifc.c2_oe;
        o.c2    = ifc.c2_o;
        o.a2    = ifc.a2_o;
        o.d2_oe = ifc.d2_oe;
        o.d2    = ifc.d2_o;
        o.wb    = ifc.wbeat_idx;
        o.rdv   = ifc.rd_valid;
        o.rdd   = ifc.rd_data;
        o.done  = ifc.done;
        o.err   = ifc.err;
        o.rid   = ifc.rsp_id;
        return o;
    endfunction

    // One whole transaction from the granting IDLE cycle through DONE.
    // delay = WAIT_RESP cycle index carrying RESPONSE; <0 or >=TIMEOUT means never.
    task automatic do_txn(input logic [1:0] valid, input logic [1:0] write,
                          input logic [14:0] a0, input logic [14:0] a1,
                          input int delay, input bit pat, input bit noise,
                          output logic [1:0] ack_seen, output logic err_seen);
        int          g, o, ws, rc, done_c;
        bit          wr, to;
        logic [14:0] addr;
        logic [15:0] rline [8];
        logic [1:0]  nr;
        obs_t        eo, ao;

        g    = valid[m_rr] ? m_rr : 1 - m_rr;
        o    = 1 - g;
        wr   = write[g];
        addr = (g == 1) ? a1 : a0;
        for (int i = 0; i < 8; i++) begin
            rline[i]    = pat ? {8'(2*i+1), 8'(2*i)} : 16'($urandom);
            wline[0][i] = 16'($urandom);
            wline[1][i] = 16'($urandom);
            if (pat) wline[g][i] = 16'hA000 + 16'(i);
        end
        ws     = (wr ? 9 : 2) + 1;
        to     = (delay < 0) || (delay >= TIMEOUT);
        rc     = ws + delay;
        done_c = to ? ws + TIMEOUT : (wr ? rc + 1 : rc + 8);
        ack_seen = 2'b00;
        err_seen = 1'b0;

        for (int c = 0; c <= done_c; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                ifc.req_valid   = valid;
                ifc.req_write   = write;
                ifc.req_addr[0] = a0;
                ifc.req_addr[1] = a1;
            end else begin
                ifc.req_valid[g] = 1'b0;
                if (noise && !valid[o])
                    ifc.req_valid[o] = (c < done_c) ? 1'($urandom) : 1'b0;
            end
            if (!to && c == rc) begin
                ifc.c2_i = CMD_RESPONSE;
                ifc.d2_i = rline[0];
            end else if (!to && !wr && c > rc && c < rc + 8) begin
                ifc.c2_i = 2'($urandom);
                ifc.d2_i = rline[c - rc];
            end else if (c >= ws && (to || c < rc) && c < done_c) begin
                nr = 2'($urandom);
                if (nr == CMD_RESPONSE) nr = CMD_NOP;
                ifc.c2_i = nr;
                ifc.d2_i = 16'($urandom);
            end else begin
                ifc.c2_i = 2'($urandom);
                ifc.d2_i = 16'($urandom);
            end

            @(negedge clk);
            eo     = '0;
            eo.rid = (c == 0) ? m_rid : 1'(g);
            eo.rdd = m_rd;
            if (c == 0) eo.ack = 2'(1 << g);
            if (c == 1 || (wr && c >= 2 && c <= 8)) begin
                eo.c2_oe = 1'b1;
                eo.c2    = wr ? CMD_WRITE_LINE : CMD_READ_LINE;
                eo.a2    = addr;
                if (wr) begin
                    eo.d2_oe = 1'b1;
                    eo.wb    = 3'(c - 1);
                    eo.d2    = wline[g][c-1];
                end
            end
            if (!wr && !to && c >= rc + 1 && c <= rc + 8) begin
                eo.rdv = 1'b1;
                eo.rdd = rline[c - rc - 1];
                m_rd   = eo.rdd;
            end
            if (c == done_c) begin
                eo.done = 2'(1 << g);
                eo.err  = to;
            end
            ao = sample();
            if (c == 0) ack_seen = ao.ack;
            if (c == done_c) err_seen = ao.err;
            chk($sformatf("txn%0d cyc%0d outputs", txn_id, c), 64'(ao), 64'(eo));
        end
        m_rr  = o;
        m_rid = 1'(g);
        txn_id++;
    endtask

    initial begin
        vec_t       vt [10];
        logic [1:0] ack;
        logic       er;
        int         r;

        vt[0] = '{2'b01, 2'b00, 15'h0012, 15'h0000,  4, 1'b1, 1'b1, 2'b01, 1'b0};
        vt[1] = '{2'b10, 2'b10, 15'h0000, 15'h7FFF,  2, 1'b1, 1'b1, 2'b10, 1'b0};
        vt[2] = '{2'b11, 2'b00, 15'h0100, 15'h0200,  0, 1'b0, 1'b0, 2'b01, 1'b0};
        vt[3] = '{2'b11, 2'b11, 15'h0101, 15'h0201,  1, 1'b0, 1'b0, 2'b10, 1'b0};
        vt[4] = '{2'b11, 2'b01, 15'h0102, 15'h0202,  3, 1'b0, 1'b0, 2'b01, 1'b0};
        vt[5] = '{2'b11, 2'b00, 15'h0103, 15'h0203,  7, 1'b0, 1'b0, 2'b10, 1'b0};
        vt[6] = '{2'b01, 2'b00, 15'h0055, 15'h0000, -1, 1'b0, 1'b1, 2'b01, 1'b1};
        vt[7] = '{2'b01, 2'b00, 15'h0056, 15'h0000, 15, 1'b0, 1'b0, 2'b01, 1'b0};
        vt[8] = '{2'b01, 2'b00, 15'h0057, 15'h0000, 16, 1'b0, 1'b0, 2'b01, 1'b1};
        vt[9] = '{2'b10, 2'b10, 15'h0000, 15'h1ABC, -1, 1'b0, 1'b1, 2'b10, 1'b1};

        n_chk = 0; n_fail = 0; txn_id = 0;
        RESET         = 1'b1;
        ifc.req_valid = 2'b11;
        ifc.req_write = 2'b00;
        ifc.req_addr  = '0;
        ifc.c2_i      = CMD_RESPONSE;
        ifc.d2_i      = 16'h5A5A;
        for (int i = 0; i < 8; i++) begin
            wline[0][i] = '0;
            wline[1][i] = '0;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("outputs during reset", 64'(sample()), 64'd0);
        ifc.req_valid = 2'b00;
        ifc.c2_i      = CMD_NOP;
        @(negedge clk);
        chk("outputs after reset", 64'(sample()), 64'd0);
        RESET = 1'b0;
        m_rr = 0; m_rid = 1'b0; m_rd = '0;

        for (int v = 0; v < 10; v++) begin
            do_txn(vt[v].valid, vt[v].write, vt[v].a0, vt[v].a1, vt[v].delay,
                   vt[v].pat, vt[v].noise, ack, er);
            chk($sformatf("vec%0d grant", v), 64'(ack), 64'(vt[v].exp_ack));
            chk($sformatf("vec%0d err", v), 64'(er), 64'(vt[v].exp_err));
        end

        // Reset in the middle of a write line, at beat 4.
        @(posedge clk); #1;
        ifc.req_valid   = 2'b01;
        ifc.req_write   = 2'b01;
        ifc.req_addr[0] = 15'h1234;
        ifc.c2_i        = CMD_NOP;
        @(negedge clk);
        chk("rst seq grant", 64'(ifc.req_ack), 64'(2'b01));
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            ifc.req_valid = 2'b00;
            @(negedge clk);
        end
        chk("rst seq beat index", 64'(ifc.wbeat_idx), 64'd4);
        chk("rst seq d2_oe before", 64'(ifc.d2_oe), 64'd1);
        RESET = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst seq outputs released", 64'(sample()), 64'd0);
        RESET = 1'b0;
        m_rr = 0; m_rid = 1'b0; m_rd = '0;
        do_txn(2'b11, 2'b00, 15'h0A0A, 15'h0B0B, 2, 1'b0, 1'b0, ack, er);
        chk("grant after mid-write reset", 64'(ack), 64'(2'b01));

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            do_txn(2'($urandom_range(1, 3)), 2'($urandom), 15'($urandom), 15'($urandom),
                   (r == 0) ? -1 : $urandom_range(0, 17), 1'b0, 1'($urandom), ack, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
